apb_cfg_arbiter: RTL and testbench
==================================

// Module: apb_cfg_arbiter
// PURPOSE
//  Shares the single APB master between NUM_REQ config requesters (coef loaders for CSC, filter1,
//  filter2, iCSC, plus a host port). Round-robin grant, one APB transfer per grant.
//  Drives the master's trigger interface and tracks completion on the APB bus.
//  Sits in the clk_apb domain between the requesters and apb_master; rtl_top is the APB slave.
// PARAMETERS
//  NUM_REQ     4    number of requesters (2..8)
//  SEL_WIDTH   4    slave-select width
//  ADDR_WIDTH  10   APB address width
//  DATA_WIDTH  32   write-data width
//  TIMEOUT     15   clk_apb cycles from trigger to ACCESS before abort (4-bit counter, 1..15)
// PORTS
//  clk_apb      in   1                     APB clock
//  rstn_apb     in   1                     reset, asynchronous, active-high
//  i_req        in   NUM_REQ               per-requester request, level, held until o_ack
//  i_wr         in   NUM_REQ               per-requester direction: 1 write, 0 read
//  i_addr       in   NUM_REQ*ADDR_WIDTH    packed addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//  i_data       in   NUM_REQ*DATA_WIDTH    packed write data
//  i_sel        in   NUM_REQ*SEL_WIDTH     packed slave selects
//  o_ack        out  NUM_REQ               one-hot, 1-cycle pulse: transfer of that requester complete
//  o_err        out  NUM_REQ               one-hot, 1-cycle pulse: transfer timed out
//  o_mst_addr   out  ADDR_WIDTH            to apb_master i_addr
//  o_mst_data   out  DATA_WIDTH            to apb_master i_data
//  o_mst_sel    out  SEL_WIDTH             to apb_master i_sel
//  o_mst_wr_trg out  1                     to apb_master i_write_trg, 1-cycle pulse
//  o_mst_rd_trg out  1                     to apb_master i_read_trg, 1-cycle pulse
//  i_psel       in   1                     monitored bus PSEL
//  i_penable    in   1                     monitored bus PENABLE
//  o_busy       out  1                     high in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rr pointer=0 (requester 0 highest priority); timeout cnt=0.
//  FSM:
//   IDLE  : if |i_req -> ARB next cycle.
//   ARB   : pick first requester with i_req=1 searching from ptr upward, wrapping NUM_REQ-1 -> 0;
//           register gnt index, latch its addr/data/sel/wr into o_mst_*; -> TRIG.
//           If i_req dropped to 0 meanwhile -> IDLE, no pulse.
//   TRIG  : assert o_mst_wr_trg (wr=1) or o_mst_rd_trg (wr=0) for exactly 1 cycle; cnt=0; -> WAIT.
//   WAIT  : cnt++ each cycle; when i_psel & i_penable sampled high -> DONE;
//           if cnt reaches TIMEOUT first -> ERR. ACCESS in the same cycle as cnt==TIMEOUT wins (DONE).
//   DONE  : o_ack[gnt]=1 for 1 cycle; ptr=gnt+1 mod NUM_REQ; -> IDLE.
//   ERR   : o_err[gnt]=1 for 1 cycle; ptr=gnt+1 mod NUM_REQ; -> IDLE.
//  o_mst_addr/data/sel stay stable from ARB until return to IDLE, then hold last value.
//  Requester must keep i_req, payload stable until o_ack/o_err; deasserting i_req after TRIG
//   does not abort the transfer (ack still pulses).
//  Requester reasserting i_req the cycle after o_ack is a new request; under contention it
//   waits behind all other pending requesters (fairness: max wait NUM_REQ-1 transfers).
//  Minimum cycles req->ack: IDLE,ARB,TRIG,WAIT(>=2: SETUP then ACCESS),DONE; back-to-back
//   grant occupies IDLE->ARB again (no IDLE skip) for deterministic spacing.
//  Only one trigger outstanding at any time; PSEL/PENABLE outside WAIT are ignored.
//  rstn_apb high mid-transfer: immediate return to reset state; no ack/err pulse; trigger
//   pulse cut; apb_master is reset by the same signal.
//  Read data is not returned by this block (write-only config path; reads used for bus exercise).
// TESTING
//  1 Single write: i_req[2]=1,wr=1,addr=0x010,data=0xA5,sel=1 -> one o_mst_wr_trg pulse with those
//    values, o_ack=4'b0100 one cycle after PSEL&PENABLE, o_busy low after.
//  2 All four requesting continuously after reset -> grant order 0,1,2,3,0,1...; each o_ack one-hot.
//  3 ptr=2 with req[0] and req[3] pending -> req[3] served first, then req[0] (wrap-around).
//  4 Bus monitor tied low, req[1]=1 -> o_err=4'b0010 exactly TIMEOUT cycles after WAIT entry, no ack,
//    next request served normally.
//  5 rstn_apb pulsed high during WAIT -> all outputs 0 immediately, no ack/err, ptr=0 afterwards.
//  6 Read request (wr=0) -> o_mst_rd_trg pulses, o_mst_wr_trg stays 0, ack on ACCESS.

Source files
------------

// File: rtl/apb_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// apb_cfg_arbiter
//   Shares the single APB master among NUM_REQ configuration requesters (CSC,
//   filter1, filter2 and iCSC coefficient loaders plus a host port). Requests
//   are granted round-robin, one APB transfer per grant. The block fires the
//   master's write/read trigger, then watches PSEL/PENABLE for the ACCESS
//   phase. If ACCESS does not arrive within TIMEOUT cycles, the transfer is
//   aborted and reported.
//
// Ports
//   clk_apb, rstn_apb          APB clock; asynchronous, active-HIGH reset
//   i_req/i_wr [NUM_REQ]       level request (held until ack/err) and direction
//   i_addr/i_data/i_sel        packed per-requester payload, requester k at
//                              [k*W +: W]
//   o_ack/o_err [NUM_REQ]      one-hot, single-cycle completion/timeout pulse
//   o_mst_addr/data/sel        payload presented to apb_master
//   o_mst_wr_trg/o_mst_rd_trg  single-cycle trigger to apb_master
//   i_psel, i_penable          monitored APB bus strobes
//   o_busy                     high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module apb_cfg_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int SEL_WIDTH  = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                          clk_apb,
  input  logic                          rstn_apb,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_REQ*SEL_WIDTH-1:0]  i_sel,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic [NUM_REQ-1:0]            o_err,
  output logic [ADDR_WIDTH-1:0]         o_mst_addr,
  output logic [DATA_WIDTH-1:0]         o_mst_data,
  output logic [SEL_WIDTH-1:0]          o_mst_sel,
  output logic                          o_mst_wr_trg,
  output logic                          o_mst_rd_trg,
  input  logic                          i_psel,
  input  logic                          i_penable,
  output logic                          o_busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_TRIG,
    ST_WAIT,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        gnt_q, gnt_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   mst_addr_q, mst_addr_d;
  logic [DATA_WIDTH-1:0]   mst_data_q, mst_data_d;
  logic [SEL_WIDTH-1:0]    mst_sel_q, mst_sel_d;
  logic                    mst_wr_q, mst_wr_d;

  logic                    arb_found;
  logic [IDX_W-1:0]        arb_idx;
  logic [ADDR_WIDTH-1:0]   arb_addr;
  logic [DATA_WIDTH-1:0]   arb_data;
  logic [SEL_WIDTH-1:0]    arb_sel;
  logic                    arb_wr;
  logic [NUM_REQ-1:0]      gnt_oh;

  // (base + off) mod NUM_REQ, for off in 0..NUM_REQ-1.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Round-robin search starting at ptr_q. Scanning offsets from the far end
  // down to 0 lets the closest pending requester overwrite earlier hits.
  // NOTE: every variable assigned in a combinational block gets a default
  // first, otherwise the paths that skip an assignment infer a latch.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[wrap_add(ptr_q, i)]) begin
        arb_found = 1'b1;
        arb_idx   = wrap_add(ptr_q, i);
      end
    end
  end

  // Payload mux for the candidate winner (constant slice bases per leg).
  always_comb begin
    arb_addr = '0;
    arb_data = '0;
    arb_sel  = '0;
    arb_wr   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_idx == IDX_W'(k)) begin
        arb_addr = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        arb_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
        arb_sel  = i_sel[k*SEL_WIDTH +: SEL_WIDTH];
        arb_wr   = i_wr[k];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    mst_addr_d = mst_addr_q;
    mst_data_d = mst_data_q;
    mst_sel_d  = mst_sel_q;
    mst_wr_d   = mst_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (|i_req) state_d = ST_ARB;
      end
      ST_ARB: begin
        // A request can be withdrawn between IDLE and ARB; go back quietly.
        if (arb_found) begin
          gnt_d      = arb_idx;
          mst_addr_d = arb_addr;
          mst_data_d = arb_data;
          mst_sel_d  = arb_sel;
          mst_wr_d   = arb_wr;
          state_d    = ST_TRIG;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TRIG: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // cnt_d is the number of WAIT cycles spent including this one, so the
        // abort lands exactly TIMEOUT cycles after WAIT entry. ACCESS seen in
        // that final cycle still completes the transfer.
        cnt_d = cnt_q + 4'd1;
        if (i_psel && i_penable) begin
          state_d = ST_DONE;
        end else if (cnt_d == 4'(TIMEOUT)) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE, ST_ERR: begin
        ptr_d   = wrap_add(gnt_q, 1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_apb or posedge rstn_apb) begin
    if (rstn_apb) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      cnt_q      <= '0;
      mst_addr_q <= '0;
      mst_data_q <= '0;
      mst_sel_q  <= '0;
      mst_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      mst_addr_q <= mst_addr_d;
      mst_data_q <= mst_data_d;
      mst_sel_q  <= mst_sel_d;
      mst_wr_q   <= mst_wr_d;
    end
  end

  // Pulses are decoded from the state register, so reset kills them at once.
  assign gnt_oh       = NUM_REQ'(1) << gnt_q;
  assign o_ack        = (state_q == ST_DONE) ? gnt_oh : '0;
  assign o_err        = (state_q == ST_ERR)  ? gnt_oh : '0;
  assign o_mst_wr_trg = (state_q == ST_TRIG) &&  mst_wr_q;
  assign o_mst_rd_trg = (state_q == ST_TRIG) && !mst_wr_q;
  assign o_mst_addr   = mst_addr_q;
  assign o_mst_data   = mst_data_q;
  assign o_mst_sel    = mst_sel_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_apb_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_cfg_arbiter
//   Directed bench for apb_cfg_arbiter. Each stimulus step pushes the expected
//   trigger and completion events into a scoreboard queue; an independent
//   monitor pops and compares on every trigger/ack/err it sees, including the
//   trigger-to-completion latency. A simple APB responder answers triggers
//   with SETUP then ACCESS after a programmable delay, or not at all.
// -----------------------------------------------------------------------------
module tb_apb_cfg_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 15;

  logic            clk_apb = 1'b0;
  logic            rstn_apb;
  logic [N-1:0]    i_req, i_wr;
  logic [N*AW-1:0] i_addr;
  logic [N*DW-1:0] i_data;
  logic [N*SW-1:0] i_sel;
  logic [N-1:0]    o_ack, o_err;
  logic [AW-1:0]   o_mst_addr;
  logic [DW-1:0]   o_mst_data;
  logic [SW-1:0]   o_mst_sel;
  logic            o_mst_wr_trg, o_mst_rd_trg;
  logic            i_psel, i_penable;
  logic            o_busy;

  apb_cfg_arbiter #(
    .NUM_REQ(N), .SEL_WIDTH(SW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk_apb(clk_apb), .rstn_apb(rstn_apb),
    .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr), .i_data(i_data), .i_sel(i_sel),
    .o_ack(o_ack), .o_err(o_err),
    .o_mst_addr(o_mst_addr), .o_mst_data(o_mst_data), .o_mst_sel(o_mst_sel),
    .o_mst_wr_trg(o_mst_wr_trg), .o_mst_rd_trg(o_mst_rd_trg),
    .i_psel(i_psel), .i_penable(i_penable), .o_busy(o_busy)
  );

  always #5 clk_apb = ~clk_apb;

  int cyc = 0;
  always @(posedge clk_apb) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          is_trig;
    bit          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] sel;
    logic [N-1:0]  ack;
    logic [N-1:0]  err;
    int            lat;
  } exp_t;

  exp_t sb_q[$];
  int   nvec  = 0;
  int   nfail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  exp_t mon_e;
  int   trig_cyc = 0;

  always @(negedge clk_apb) begin
    if (o_mst_wr_trg || o_mst_rd_trg || (|o_ack) || (|o_err)) begin
      if (sb_q.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL unexpected_event: wr=%0b rd=%0b ack=%b err=%b with empty scoreboard",
                 o_mst_wr_trg, o_mst_rd_trg, o_ack, o_err);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.is_trig) begin
          trig_cyc = cyc;
          check("trig_wr",   {63'd0, o_mst_wr_trg}, {63'd0, mon_e.wr});
          check("trig_rd",   {63'd0, o_mst_rd_trg}, {63'd0, !mon_e.wr});
          check("trig_addr", 64'(o_mst_addr), 64'(mon_e.addr));
          check("trig_data", 64'(o_mst_data), 64'(mon_e.data));
          check("trig_sel",  64'(o_mst_sel),  64'(mon_e.sel));
        end else begin
          check("cpl_ack", 64'(o_ack), 64'(mon_e.ack));
          check("cpl_err", 64'(o_err), 64'(mon_e.err));
          check("cpl_lat", 64'(cyc - trig_cyc), 64'(mon_e.lat));
        end
      end
    end
  end

  // kind: 0 = ack, 1 = err, 2 = no completion expected
  task automatic expect_xfer(input int k, input bit wr, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data, input logic [SW-1:0] sel,
                             input int kind, input int lat);
    exp_t e;
    e = '{is_trig: 1'b1, wr: wr, addr: addr, data: data, sel: sel,
          ack: '0, err: '0, lat: 0};
    sb_q.push_back(e);
    if (kind != 2) begin
      e.is_trig = 1'b0;
      e.ack     = (kind == 0) ? N'(1) << k : '0;
      e.err     = (kind == 1) ? N'(1) << k : '0;
      e.lat     = lat;
      sb_q.push_back(e);
    end
  endtask

  // ---------------- APB responder ----------------
  bit bus_en  = 1'b1;
  int bus_dly = 0;

  initial begin
    i_psel    = 1'b0;
    i_penable = 1'b0;
    forever begin
      @(negedge clk_apb);
      if ((o_mst_wr_trg || o_mst_rd_trg) && bus_en) begin
        repeat (bus_dly + 1) @(posedge clk_apb);
        #1 i_psel = 1'b1;
        @(posedge clk_apb);
        #1 i_penable = 1'b1;
        @(posedge clk_apb);
        #1;
        i_psel    = 1'b0;
        i_penable = 1'b0;
      end
    end
  end

  // ---------------- requesters ----------------
  int rem [N];

  task automatic issue(input int k, input bit wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input logic [SW-1:0] sel, input int n);
    i_wr[k]             = wr;
    i_addr[k*AW +: AW]  = addr;
    i_data[k*DW +: DW]  = data;
    i_sel[k*SW +: SW]   = sel;
    rem[k]              = n;
    i_req[k]            = 1'b1;
  endtask

  // Requesters hold i_req until their last ack/err, then drop it.
  task automatic run(input int budget);
    int c;
    c = 0;
    while (i_req != '0 && c < budget) begin
      @(negedge clk_apb);
      c++;
      for (int k = 0; k < N; k++) begin
        if (o_ack[k] || o_err[k]) begin
          if (rem[k] > 0) rem[k]--;
          if (rem[k] == 0) i_req[k] = 1'b0;
        end
      end
    end
    check("run_drained", 64'(i_req), 64'd0);
  endtask

  task automatic check_quiet(input string name);
    check(name, {o_busy, o_mst_wr_trg, o_mst_rd_trg, o_ack, o_err,
                 o_mst_addr, o_mst_data, o_mst_sel}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int c;
    rstn_apb = 1'b1;
    i_req    = '0;
    i_wr     = '0;
    i_addr   = '0;
    i_data   = '0;
    i_sel    = '0;
    for (int k = 0; k < N; k++) rem[k] = 0;

    repeat (3) @(negedge clk_apb);
    check_quiet("reset_outputs");
    rstn_apb = 1'b0;
    @(negedge clk_apb);
    check("idle_busy", 64'(o_busy), 64'd0);

    // Single write from requester 2 (ptr 0 -> 3).
    expect_xfer(2, 1'b1, 10'h010, 32'h0000_00A5, 4'h1, 0, 3);
    issue(2, 1'b1, 10'h010, 32'h0000_00A5, 4'h1, 1);
    run(100);
    @(negedge clk_apb);
    check("t1_busy_after", 64'(o_busy), 64'd0);

    // Read from requester 0 (search wraps 3 -> 0; ptr -> 1).
    expect_xfer(0, 1'b0, 10'h020, 32'h0000_BEEF, 4'h2, 0, 3);
    issue(0, 1'b0, 10'h020, 32'h0000_BEEF, 4'h2, 1);
    run(100);
    repeat (2) @(negedge clk_apb);

    // Timeout on requester 1: err TO cycles after WAIT entry (TO+1 after trigger).
    bus_en = 1'b0;
    expect_xfer(1, 1'b1, 10'h030, 32'h0000_0011, 4'h3, 1, TO + 1);
    issue(1, 1'b1, 10'h030, 32'h0000_0011, 4'h3, 1);
    run(100);
    @(negedge clk_apb);
    check("t4_busy_after", 64'(o_busy), 64'd0);
    bus_en = 1'b1;

    // ptr = 2 with requesters 0 and 3 pending: 3 first, then 0.
    expect_xfer(3, 1'b1, 10'h043, 32'h0000_0033, 4'h5, 0, 3);
    expect_xfer(0, 1'b1, 10'h040, 32'h0000_0022, 4'h4, 0, 3);
    issue(0, 1'b1, 10'h040, 32'h0000_0022, 4'h4, 1);
    issue(3, 1'b1, 10'h043, 32'h0000_0033, 4'h5, 1);
    run(100);
    repeat (2) @(negedge clk_apb);

    // ACCESS in the last WAIT cycle still completes (requester 1).
    bus_dly = TO - 2;
    expect_xfer(1, 1'b1, 10'h050, 32'h0000_0044, 4'h6, 0, TO + 1);
    issue(1, 1'b1, 10'h050, 32'h0000_0044, 4'h6, 1);
    run(100);
    repeat (3) @(negedge clk_apb);

    // ACCESS one cycle too late: timeout, and the late strobes are ignored.
    bus_dly = TO - 1;
    expect_xfer(2, 1'b1, 10'h060, 32'h0000_0055, 4'h7, 1, TO + 1);
    issue(2, 1'b1, 10'h060, 32'h0000_0055, 4'h7, 1);
    run(100);
    repeat (4) @(negedge clk_apb);
    check("late_access_ignored", 64'(o_busy), 64'd0);
    bus_dly = 0;

    // Reset during WAIT on requester 3 (ptr is 3 beforehand).
    expect_xfer(3, 1'b1, 10'h070, 32'h0000_0066, 4'h8, 2, 0);
    issue(3, 1'b1, 10'h070, 32'h0000_0066, 4'h8, 1);
    c = 0;
    while (!(o_mst_wr_trg || o_mst_rd_trg) && c < 20) begin
      @(negedge clk_apb);
      c++;
    end
    check("t5_trigger_seen", 64'(o_mst_wr_trg), 64'd1);
    @(posedge clk_apb);
    #2;
    check("t5_busy_in_wait", 64'(o_busy), 64'd1);
    rstn_apb = 1'b1;
    #1;
    check_quiet("t5_reset_outputs");
    i_req = '0;
    for (int k = 0; k < N; k++) rem[k] = 0;
    repeat (3) @(negedge clk_apb);
    check_quiet("t5_reset_held");
    rstn_apb = 1'b0;
    repeat (2) @(negedge clk_apb);

    // All four requesting continuously: ptr back at 0 gives 0,1,2,3,0,1,2,3.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < N; k++) begin
        expect_xfer(k, (k % 2) == 0, AW'(10'h100 + k), DW'(32'h1000 + k), SW'(k), 0, 3);
      end
    end
    for (int k = 0; k < N; k++) begin
      issue(k, (k % 2) == 0, AW'(10'h100 + k), DW'(32'h1000 + k), SW'(k), 2);
    end
    run(400);
    repeat (3) @(negedge clk_apb);
    check("final_busy", 64'(o_busy), 64'd0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
